// File: rtl/memory_stage.sv
// LEGv8 MEM stage: EX/MEM register, req/ack data-memory access FSM with timeout,
// branch resolution and MEM/WB register. Stalls upstream while an access is pending.
module memory_stage #(
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_E,
  input  logic              flush_E,
  input  logic              Branch_E,
  input  logic              MemRead_E,
  input  logic              MemWrite_E,
  input  logic              RegWrite_E,
  input  logic              MemtoReg_E,
  input  logic [4:0]        rd_E,
  input  logic [DATA_W-1:0] PCBranch_E,
  input  logic [DATA_W-1:0] aluResult_E,
  input  logic [DATA_W-1:0] writeData_E,
  input  logic              zero_E,
  output logic              dm_req,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ack,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              stall_M,
  output logic              PCSrc_M,
  output logic [DATA_W-1:0] PCBranch_M,
  output logic              misalign_M,
  output logic              err_M,
  output logic              valid_W,
  output logic              RegWrite_W,
  output logic              MemtoReg_W,
  output logic [4:0]        rd_W,
  output logic [DATA_W-1:0] aluResult_W,
  output logic [DATA_W-1:0] readData_W
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;

  logic              valid_M;
  logic              Branch_M;
  logic              MemRead_M;
  logic              MemWrite_M;
  logic              RegWrite_M;
  logic              MemtoReg_M;
  logic              zero_M;
  logic [4:0]        rd_M;
  logic [DATA_W-1:0] aluResult_M;
  logic [DATA_W-1:0] writeData_M;

  logic              mem_op;
  logic              misal;
  logic              load_ack;
  logic              fault;

  // EX/MEM boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_M     <= 1'b0;
      Branch_M    <= 1'b0;
      MemRead_M   <= 1'b0;
      MemWrite_M  <= 1'b0;
      RegWrite_M  <= 1'b0;
      MemtoReg_M  <= 1'b0;
      zero_M      <= 1'b0;
      rd_M        <= '0;
      PCBranch_M  <= '0;
      aluResult_M <= '0;
      writeData_M <= '0;
    end else if (!stall_M) begin
      valid_M     <= valid_E & ~flush_E;
      Branch_M    <= Branch_E;
      MemRead_M   <= MemRead_E;
      MemWrite_M  <= MemWrite_E;
      RegWrite_M  <= RegWrite_E;
      MemtoReg_M  <= MemtoReg_E;
      zero_M      <= zero_E;
      rd_M        <= rd_E;
      PCBranch_M  <= PCBranch_E;
      aluResult_M <= aluResult_E;
      writeData_M <= writeData_E;
    end
  end

  assign mem_op   = valid_M & (MemRead_M | MemWrite_M);
  assign misal    = |aluResult_M[2:0];
  assign PCSrc_M  = valid_M & Branch_M & zero_M;
  assign dm_addr  = aluResult_M;
  assign dm_wdata = writeData_M;
  assign dm_we    = dm_req & MemWrite_M;

  // Request is held through the final WAIT cycle; an ack there still completes normally.
  always_comb begin
    dm_req     = 1'b0;
    stall_M    = 1'b0;
    misalign_M = 1'b0;
    err_M      = 1'b0;
    case (state)
      S_IDLE: begin
        if (mem_op) begin
          if (misal) begin
            misalign_M = 1'b1;
          end else begin
            dm_req  = 1'b1;
            stall_M = ~dm_ack;
          end
        end
      end
      S_WAIT: begin
        dm_req  = 1'b1;
        err_M   = ~dm_ack & (cnt == CNT_W'(TIMEOUT - 1));
        stall_M = ~dm_ack & ~err_M;
      end
      default: ;
    endcase
  end

  assign load_ack = dm_req & dm_ack & ~MemWrite_M;
  assign fault    = misalign_M | err_M;

  // Access FSM; cnt counts request cycles already spent without an ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (dm_req && !dm_ack) begin
            state <= S_WAIT;
            cnt   <= CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (dm_ack || err_M) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // MEM/WB boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_W     <= 1'b0;
      RegWrite_W  <= 1'b0;
      MemtoReg_W  <= 1'b0;
      rd_W        <= '0;
      aluResult_W <= '0;
      readData_W  <= '0;
    end else if (stall_M) begin
      valid_W    <= 1'b0;
      RegWrite_W <= 1'b0;
    end else begin
      valid_W     <= valid_M;
      RegWrite_W  <= RegWrite_M & valid_M & ~fault;
      MemtoReg_W  <= MemtoReg_M;
      rd_W        <= rd_M;
      aluResult_W <= aluResult_M;
      readData_W  <= load_ack ? dm_rdata : '0;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: transaction-level reference model feeding a scoreboard,
// a latency-programmable memory responder, and a decoupled writeback monitor.
module tb_memory_stage;
  localparam int DATA_W  = 64;
  localparam int TIMEOUT = 16;
  localparam int NEVER   = 1000;

  logic clk = 1'b0;
  logic reset;
  logic valid_E, flush_E, Branch_E, MemRead_E, MemWrite_E, RegWrite_E, MemtoReg_E, zero_E;
  logic [4:0] rd_E;
  logic [DATA_W-1:0] PCBranch_E, aluResult_E, writeData_E;
  logic dm_req, dm_we, dm_ack;
  logic [DATA_W-1:0] dm_addr, dm_wdata, dm_rdata;
  logic stall_M, PCSrc_M, misalign_M, err_M;
  logic [DATA_W-1:0] PCBranch_M;
  logic valid_W, RegWrite_W, MemtoReg_W;
  logic [4:0] rd_W;
  logic [DATA_W-1:0] aluResult_W, readData_W;

  always #5 clk = ~clk;

  memory_stage #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .valid_E(valid_E), .flush_E(flush_E),
    .Branch_E(Branch_E), .MemRead_E(MemRead_E), .MemWrite_E(MemWrite_E),
    .RegWrite_E(RegWrite_E), .MemtoReg_E(MemtoReg_E), .rd_E(rd_E),
    .PCBranch_E(PCBranch_E), .aluResult_E(aluResult_E), .writeData_E(writeData_E),
    .zero_E(zero_E), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata), .stall_M(stall_M),
    .PCSrc_M(PCSrc_M), .PCBranch_M(PCBranch_M), .misalign_M(misalign_M),
    .err_M(err_M), .valid_W(valid_W), .RegWrite_W(RegWrite_W),
    .MemtoReg_W(MemtoReg_W), .rd_W(rd_W), .aluResult_W(aluResult_W),
    .readData_W(readData_W)
  );

  typedef struct {
    logic ve, fl, v, br, mr, mw, rw, m2r, zero;
    logic [4:0] rd;
    logic [63:0] pcb, alu, wd;
    int lat;
  } instr_t;

  typedef struct {
    logic [4:0] rd;
    logic rw, m2r;
    logic [63:0] alu, rdata;
  } wb_t;

  wb_t exp_q[$];
  int  lat_q[$];
  logic [63:0] ref_mem  [logic [63:0]];
  logic [63:0] resp_mem [logic [63:0]];
  instr_t cur_m;
  int errors = 0;
  int checks = 0;

  function automatic logic [63:0] init_val(input logic [63:0] a);
    return {a[31:0] ^ 32'hA5A5_1234, 32'hC0DE_0000 | {16'h0, a[15:0]}};
  endfunction

  function automatic logic is_req(input instr_t m);
    return m.v && (m.mr || m.mw) && (m.alu[2:0] == 3'd0);
  endfunction

  function automatic logic is_mis(input instr_t m);
    return m.v && (m.mr || m.mw) && (m.alu[2:0] != 3'd0);
  endfunction

  function automatic logic is_to(input instr_t m);
    return is_req(m) && (m.lat > TIMEOUT);
  endfunction

  function automatic int exp_stall(input instr_t m);
    if (!is_req(m)) return 0;
    return ((m.lat < TIMEOUT) ? m.lat : TIMEOUT) - 1;
  endfunction

  function automatic instr_t mk(input logic ve, fl, br, mr, mw, rw, m2r, zero,
                                input logic [4:0] rd, input logic [63:0] pcb, alu, wd,
                                input int lat);
    instr_t x;
    x.ve = ve; x.fl = fl; x.v = ve & ~fl; x.br = br; x.mr = mr; x.mw = mw;
    x.rw = rw; x.m2r = m2r; x.zero = zero; x.rd = rd; x.pcb = pcb;
    x.alu = alu; x.wd = wd; x.lat = lat;
    return x;
  endfunction

  function automatic instr_t bubble();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 64'd0, 64'd0, 64'd0, 1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: outcome of one instruction, decided from its operands and memory latency.
  task automatic model_push(input instr_t x);
    wb_t w;
    if (!x.v) return;
    w.rd = x.rd; w.m2r = x.m2r; w.alu = x.alu; w.rdata = 64'd0; w.rw = x.rw;
    if (is_mis(x)) begin
      w.rw = 1'b0;
    end else if (is_req(x)) begin
      lat_q.push_back(x.lat);
      if (x.lat > TIMEOUT) w.rw = 1'b0;
      else if (x.mw) ref_mem[x.alu] = x.wd;
      else w.rdata = ref_mem.exists(x.alu) ? ref_mem[x.alu] : init_val(x.alu);
    end
    exp_q.push_back(w);
  endtask

  task automatic check_m(input int cyc);
    logic req;
    req = is_req(cur_m);
    chk("PCSrc_M", PCSrc_M, cur_m.v & cur_m.br & cur_m.zero);
    chk("PCBranch_M", PCBranch_M, cur_m.pcb);
    chk("dm_req", dm_req, req);
    if (req) begin
      chk("dm_we", dm_we, cur_m.mw);
      chk("dm_addr", dm_addr, cur_m.alu);
      chk("dm_wdata", dm_wdata, cur_m.wd);
    end
    chk("misalign_M", misalign_M, is_mis(cur_m));
    chk("err_M", err_M, is_to(cur_m) && (cyc == TIMEOUT - 1));
  endtask

  task automatic drive(input instr_t x);
    valid_E = x.ve; flush_E = x.fl; Branch_E = x.br; MemRead_E = x.mr;
    MemWrite_E = x.mw; RegWrite_E = x.rw; MemtoReg_E = x.m2r; zero_E = x.zero;
    rd_E = x.rd; PCBranch_E = x.pcb; aluResult_E = x.alu; writeData_E = x.wd;
  endtask

  task automatic issue(input instr_t x);
    int cyc;
    logic st;
    cyc = 0;
    drive(x);
    forever begin
      @(negedge clk); #1;
      check_m(cyc);
      st = stall_M;
      @(posedge clk); #1;
      if (!st) break;
      cyc++;
      if (cyc > 4 * TIMEOUT) begin
        checks++; errors++;
        $display("FAIL stall_bound: still stalled after %0d cycles", cyc);
        break;
      end
    end
    chk("stall_cycles", 64'(cyc), 64'(exp_stall(cur_m)));
    model_push(x);
    cur_m = x;
  endtask

  function automatic instr_t rnd();
    int op, r, lat;
    logic [63:0] alu;
    op = $urandom_range(0, 3);
    alu = {$urandom, $urandom};
    if (op == 1 || op == 2) begin
      alu = 64'($urandom_range(0, 15)) * 64'd8;
      if ($urandom_range(0, 5) == 0) alu = alu + 64'($urandom_range(1, 7));
    end
    r = $urandom_range(0, 9);
    if (r <= 6)      lat = $urandom_range(1, 3);
    else if (r == 7) lat = TIMEOUT;
    else if (r == 8) lat = NEVER;
    else             lat = $urandom_range(4, 8);
    return mk(($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0),
              (op == 3), (op == 1), (op == 2), 1'($urandom), (op == 1), 1'($urandom),
              5'($urandom), {$urandom, $urandom}, alu, {$urandom, $urandom}, lat);
  endfunction

  // Memory responder: acks after the programmed number of request cycles.
  int r_active = 0, r_n = 0, r_lat = 0;
  initial begin
    dm_ack = 1'b0;
    dm_rdata = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        r_active = 0;
        dm_ack = 1'b0;
      end else if (dm_req) begin
        if (r_active == 0) begin
          if (lat_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_req: addr %h with no request pending", dm_addr);
            r_lat = 1;
          end else begin
            r_lat = lat_q.pop_front();
          end
          r_active = 1;
          r_n = 0;
        end
        r_n++;
        if (r_n == r_lat) begin
          dm_ack = 1'b1;
          if (dm_we) begin
            resp_mem[dm_addr] = dm_wdata;
            dm_rdata = {$urandom, $urandom};
          end else begin
            dm_rdata = resp_mem.exists(dm_addr) ? resp_mem[dm_addr] : init_val(dm_addr);
          end
          r_active = 0;
        end else begin
          dm_ack = 1'b0;
          dm_rdata = {$urandom, $urandom};
          if (r_n >= TIMEOUT) r_active = 0;
        end
      end else begin
        r_active = 0;
        dm_ack = 1'($urandom);
        dm_rdata = {$urandom, $urandom};
      end
    end
  end

  // Writeback monitor
  initial begin
    wb_t e;
    forever begin
      @(posedge clk); #2;
      if (valid_W) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_wb: rd %0d with nothing expected", rd_W);
        end else begin
          e = exp_q.pop_front();
          chk("wb_rd", 64'(rd_W), 64'(e.rd));
          chk("wb_RegWrite", 64'(RegWrite_W), 64'(e.rw));
          chk("wb_MemtoReg", 64'(MemtoReg_W), 64'(e.m2r));
          chk("wb_aluResult", aluResult_W, e.alu);
          chk("wb_readData", readData_W, e.rdata);
        end
      end else begin
        chk("bubble_RegWrite_W", 64'(RegWrite_W), 64'd0);
      end
    end
  end

  initial begin
    reset = 1'b1;
    cur_m = bubble();
    drive(cur_m);
    #12;
    chk("rst_dm_req", dm_req, 0);
    chk("rst_stall_M", stall_M, 0);
    chk("rst_PCSrc_M", PCSrc_M, 0);
    chk("rst_valid_W", valid_W, 0);
    chk("rst_RegWrite_W", RegWrite_W, 0);
    chk("rst_readData_W", readData_W, 0);
    @(negedge clk); #2 reset = 1'b0;
    @(posedge clk); #1;

    ref_mem[64'd16]  = 64'hDEAD;
    resp_mem[64'd16] = 64'hDEAD;
    issue(mk(1, 0, 0, 1, 0, 1, 1, 0, 5'd5, 64'd0, 64'd16, 64'd0, 1));
    issue(mk(1, 0, 0, 0, 1, 0, 0, 0, 5'd6, 64'd0, 64'd40, 64'd25, 3));
    issue(mk(1, 0, 1, 0, 0, 0, 0, 1, 5'd0, 64'd68, 64'd0, 64'd0, 1));
    issue(mk(1, 0, 1, 0, 0, 0, 0, 0, 5'd0, 64'd68, 64'd1, 64'd0, 1));
    issue(mk(1, 0, 0, 1, 0, 1, 1, 0, 5'd7, 64'd0, 64'd13, 64'd0, 1));
    issue(mk(1, 0, 0, 1, 0, 1, 1, 0, 5'd8, 64'd0, 64'd24, 64'd0, NEVER));
    issue(mk(1, 0, 0, 1, 0, 1, 1, 0, 5'd9, 64'd0, 64'd40, 64'd0, 2));
    for (int i = 0; i < 250; i++) issue(rnd());
    repeat (3) issue(bubble());

    // Reset while a load is waiting on memory
    drive(mk(1, 0, 0, 1, 0, 1, 1, 0, 5'd3, 64'd0, 64'd32, 64'd0, NEVER));
    @(posedge clk); #1;
    lat_q.push_back(NEVER);
    drive(bubble());
    repeat (3) @(negedge clk);
    #1;
    chk("pre_rst_dm_req", dm_req, 1);
    chk("pre_rst_stall_M", stall_M, 1);
    reset = 1'b1;
    #1;
    chk("midrst_dm_req", dm_req, 0);
    chk("midrst_stall_M", stall_M, 0);
    chk("midrst_valid_W", valid_W, 0);
    lat_q.delete();
    exp_q.delete();
    cur_m = bubble();
    @(negedge clk); #2 reset = 1'b0;
    @(posedge clk); #1;
    issue(mk(1, 0, 0, 1, 0, 1, 1, 0, 5'd4, 64'd0, 64'd16, 64'd0, 2));
    repeat (3) issue(bubble());
    @(posedge clk); #3;
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("latency_queue_empty", 64'(lat_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
